// File: rtl/pipe_mux.sv
// pipe_mux: one-cycle registered N:1 mux with stall/flush, saturating stall counter and sticky select error
module pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic                    sel_err
);
    logic [WIDTH-1:0] out_q, out_d, pick;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             in_range;
    logic             capture;

    assign in_range = 32'(sel) < NUM_IN;
    assign capture  = !flush && !stall;

    // pick the addressed input; an out-of-range index yields all-zero
    always_comb begin
        pick = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (32'(sel) == k) pick = in_bus[k*WIDTH +: WIDTH];
    end

    // next state with flush over stall over capture; reset is applied in the register block
    always_comb begin
        out_d   = flush ? '0 : stall ? out_q : pick;
        valid_d = !flush && (stall ? valid_q : in_valid);
        sel_d   = flush ? '0 : stall ? sel_q : sel;
        cnt_d   = (flush || !stall) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
        err_d   = err_q || (capture && in_valid && !in_range);
    end

    // state registers with synchronous reset; every output comes straight from here
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;
    assign stall_cnt = cnt_q;
    assign sel_err   = err_q;
endmodule
